// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch, data and optional loader (MEM_PORT_ARB_LOADER_EN) onto
// one fixed-latency synchronous memory port, one access in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 128,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
`ifdef MEM_PORT_ARB_LOADER_EN
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              oor,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ID_IF, ID_D, ID_LD
  } id_t;

  localparam logic [3:0]  LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [31:0] DEPTH  = 32'(MEM_DEPTH);

  state_t            r_state;
  state_t            w_next;
  id_t               r_id;
  id_t               w_win_id;
  logic              r_we;
  logic              r_oor;
  logic              r_rr_d;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [3:0]        r_cnt;
  logic              w_any;
  logic              w_win_we;
  logic              w_win_oor;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_issue;
  logic              w_resp;

  // r_rr_d set means data wins the next data/fetch tie
  always_comb begin
    w_win_id    = ID_IF;
    w_win_we    = 1'b0;
    w_win_addr  = if_addr;
    w_win_wdata = '0;
`ifdef MEM_PORT_ARB_LOADER_EN
    w_any = ld_req | d_req | if_req;
    if (ld_req) begin
      w_win_id    = ID_LD;
      w_win_we    = 1'b1;
      w_win_addr  = ld_addr;
      w_win_wdata = ld_wdata;
    end else
`else
    w_any = d_req | if_req;
`endif
    if (d_req && (r_rr_d || !if_req)) begin
      w_win_id    = ID_D;
      w_win_we    = d_we;
      w_win_addr  = d_addr;
      w_win_wdata = d_wdata;
    end
  end

  assign w_win_oor = 32'(w_win_addr) >= DEPTH;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= ID_IF;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_rr_d  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_win_id;
            r_we    <= w_win_we;
            r_oor   <= w_win_oor;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            if (w_win_id == ID_D)  r_rr_d <= 1'b0;
            if (w_win_id == ID_IF) r_rr_d <= 1'b1;
          end
        end
        S_ISSUE: r_cnt <= LAT_M1;
        S_WAIT: begin
          if (r_cnt == 4'd0)
            r_rdata <= r_oor ? '0 : mem_rdata;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_issue   = r_state == S_ISSUE;
  assign w_resp    = r_state == S_RESP;
  assign if_gnt    = w_issue && (r_id == ID_IF);
  assign d_gnt     = w_issue && (r_id == ID_D);
  assign if_rvalid = w_resp && (r_id == ID_IF);
  assign d_rvalid  = w_resp && (r_id == ID_D);
`ifdef MEM_PORT_ARB_LOADER_EN
  assign ld_gnt    = w_issue && (r_id == ID_LD);
`endif
  assign oor       = w_issue && r_oor;
  assign mem_en    = w_issue && !r_oor;
  assign mem_we    = mem_en && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;
  assign busy      = r_state != S_IDLE;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single unified program/data memory between three requesters: the instruction-fetch stage, the load/store stage, and an optional external program loader. One access is outstanding at a time. The arbiter sequences each access through a fixed-latency synchronous memory port and returns read data with a per-requester valid strobe. It sits between the core's fetch/execute logic and the memory array, replacing direct array indexing by the core.

## Interface
- ADDR_W, 8, word address width (all requesters, memory port)
- DATA_W, 64, memory word width; fetch consumes rdata[31:0]
- MEM_DEPTH, 128, number of implemented words; addresses >= MEM_DEPTH are out of range
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch grant pulse
- if_rvalid  out  1  fetch read data valid pulse
- d_req  in  1  data request
- d_we  in  1  data write (1) / read (0)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write value
- d_gnt  out  1  data grant pulse
- d_rvalid  out  1  data read data valid pulse
- ld_req / ld_addr / ld_wdata / ld_gnt  in/in/in/out  1/ADDR_W/DATA_W/1  loader write port (write-only; present only with MEM_PORT_ARB_LOADER_EN)
- rdata  out  DATA_W  registered read data, shared by all requesters
- oor  out  1  out-of-range pulse, coincident with the grant
- busy  out  1  high in every state except IDLE
- mem_en, mem_we  out  1  memory strobe / write enable
- mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W;  mem_rdata  in  DATA_W

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, latch the winner's id, addr, we and wdata, then go to ISSUE. Otherwise stay.
- Priority: loader is absolute. Between data and fetch, round-robin: after a data grant fetch wins the next tie, and vice versa. The pointer starts at fetch after reset.
- ISSUE: the winner's gnt is high for exactly one cycle, with mem_en=1 and mem_addr/mem_we/mem_wdata taken from the latched values.
  - Write: go to IDLE.
  - Read: go to WAIT with cnt = MEM_LAT-1.
- WAIT: if cnt==0, capture mem_rdata into rdata and go to RESP; otherwise decrement cnt.
- RESP: the winner's rvalid is high for one cycle, then go to IDLE. rdata holds its value until the next capture.
- Out of range (latched addr >= MEM_DEPTH):
  - oor pulses together with the grant, and mem_en stays 0.
  - Write: dropped, go to IDLE.
  - Read: WAIT/RESP proceed normally, with rdata = 0.
- Requester rules:
  - A requester holds req, addr, we and wdata stable until its gnt.
  - Deasserting req before gnt withdraws the request. This is legal only while busy=0 or while another requester is being served.
  - Requests arriving while busy are ignored until IDLE.
- Arithmetic: cnt is 4 bits. The address compare is unsigned at ADDR_W bits.

## Timing
- Reset values:
  - State IDLE; cnt=0; round-robin pointer = fetch.
  - rdata=0.
  - Every gnt, rvalid, oor, mem_en, mem_we, busy = 0.
  - mem_addr=0, mem_wdata=0.
- All outputs are registered or decoded from state/latched registers only. There is no combinational path from req to gnt.
- Read, request seen in IDLE at cycle t:
  - gnt/mem_en at t+1.
  - mem_rdata sampled at t+1+MEM_LAT.
  - rvalid at t+2+MEM_LAT.
  - Next arbitration at t+3+MEM_LAT.
- Write, request seen in IDLE at cycle t: gnt/mem_en/mem_we at t+1; next arbitration at t+2.
- Simultaneous requests are resolved in the single IDLE sampling cycle. Losers wait in IDLE for the next arbitration.
- rst asserted in any state:
  - Next cycle is IDLE with all pulses low.
  - A pending rvalid is discarded, and the latched request is dropped.
  - A write already issued to memory is not undone.

## Configuration
- MEM_PORT_ARB_LOADER_EN defined: the ld_* ports exist, and the loader has absolute priority. Loader accesses are always writes and never produce rvalid.
- Undefined: the ld_* ports are absent, and arbitration is only data/fetch round-robin. All other timing is unchanged.

## Test plan
- Single fetch read, MEM_LAT=1, if_addr=5, mem_rdata=0x00000000_91000421 → if_gnt at t+1, rdata=0x91000421 and if_rvalid at t+3, busy low at t+4.
- if_req and d_req (read, addr 3) both high at reset+1 → data is not granted first (pointer=fetch); fetch granted, then data granted at the next IDLE, then fetch wins the following tie after data.
- Data write, d_addr=0x10, d_wdata=0xDEADBEEF → d_gnt with mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF in the same cycle, no d_rvalid, IDLE at t+2.
- MEM_LAT=4 read → if_rvalid exactly at t+6; read with d_addr=200 → oor with d_gnt, mem_en=0, d_rvalid with rdata=0.
- rst asserted during WAIT → no rvalid, busy=0 the next cycle, a subsequent fetch is served normally.
- With MEM_PORT_ARB_LOADER_EN, ld_req + d_req + if_req together → ld_gnt first, then round-robin data/fetch.
